axis_inject_arbiter: RTL and testbench
======================================

Name: axis_inject_arbiter

Overview:
- Packet-level round-robin arbiter that lets NUM_REQ local AXI-Stream sources share one mesh injection port (the axis_in_* side of one node of axis_mesh).
- A grant is held from a packet's first beat through its TLAST beat, so packets from different sources are never interleaved inside the NoC.
- Output passes through a 2-entry registered buffer, so there is no combinational path from M_TREADY to any S_TREADY.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TDATAW, 32, tdata width.
- TDESTW, 4, tdest width.

Ports:
- CLK  in  1  user clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- AXIS_S_TVALID  in  NUM_REQ  per-requester valid.
- AXIS_S_TREADY  out  NUM_REQ  per-requester ready.
- AXIS_S_TDATA  in  NUM_REQ*TDATAW  requester i at bits [i*TDATAW +: TDATAW].
- AXIS_S_TLAST  in  NUM_REQ  per-requester last.
- AXIS_S_TDEST  in  NUM_REQ*TDESTW  requester i at bits [i*TDESTW +: TDESTW].
- AXIS_M_TVALID  out  1  to mesh axis_in_tvalid.
- AXIS_M_TREADY  in  1  from mesh axis_in_tready.
- AXIS_M_TDATA  out  TDATAW  to mesh.
- AXIS_M_TLAST  out  1  to mesh.
- AXIS_M_TDEST  out  TDESTW  to mesh.
- GRANT  out  NUM_REQ  one-hot current grant; 0 when idle.
- PKT_CNT  out  16  count of packets fully accepted (TLAST beats taken), wraps at 16'hFFFF->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, buffer count=0, AXIS_M_TVALID=0, AXIS_M_TDATA/TLAST/TDEST=0, AXIS_S_TREADY=0, GRANT=0, PKT_CNT=0.
- Reset mid-packet: buffered beats are discarded. The partial packet is not resumed; the source must restart it.

State machine:
- IDLE:
  - If any AXIS_S_TVALID is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register GRANT and move to LOCKED on the next edge.
  - No beat is accepted in IDLE, giving a 1-cycle arbitration bubble per packet.
  - If no valid is high, stay in IDLE.
- LOCKED:
  - AXIS_S_TREADY[g] = (count<2) for the granted index g; all other S_TREADY bits are 0.
  - A beat is accepted when S_TVALID[g] & S_TREADY[g].
  - On an accepted beat with TLAST=1: next state IDLE, rr_ptr = (g+1) mod NUM_REQ, PKT_CNT increments, GRANT clears on the same edge.
  - If the granted source drops TVALID mid-packet, the grant is held indefinitely; no other source is served.

Buffer (2-entry FIFO of {TDATA,TLAST,TDEST}):
- A beat accepted at edge t is visible on AXIS_M_* after edge t (1-cycle latency).
- AXIS_M_TVALID = (count>0), driven from a register.
- Head output is held stable while TVALID=1 and TREADY=0 (AXI-Stream rule).
- Push and pop in the same cycle: count unchanged, order preserved.
- count==2: S_TREADY deasserts. With M_TREADY held high, throughput is 1 beat/cycle.
- count==0: M_TVALID=0; M_TDATA/TLAST/TDEST hold their last values.

Additional rules:
- Single-beat packet (TLAST on the first beat): LOCKED for exactly one accept, then IDLE.
- Back-to-back packets from the same source incur the IDLE bubble. Fairness: after a packet from source i, source i has lowest priority.
- TDEST passes through unchanged per beat. Destination consistency within a packet is the source's responsibility.

Test Plan:
- NUM_REQ=4; source 2 sends 3 beats (data 0xA0,0xA1,0xA2, tdest 3, last on beat 3), M_TREADY=1 -> GRANT=4'b0100 one cycle after TVALID; M beats 0xA0..0xA2 on consecutive cycles with TLAST on 0xA2; PKT_CNT=1; rr_ptr=3.
- Sources 0,1,3 all valid with 2-beat packets from reset -> grant order 0,1,3,0,... with no beat interleaving on M; PKT_CNT=3 after the first three packets.
- Source 0 drops TVALID for 5 cycles after beat 1 while source 1 is valid -> GRANT stays 4'b0001; S_TREADY[1]=0 throughout; source 1 is served only after source 0's TLAST.
- M_TREADY=0 while source 0 streams 0x10,0x11,0x12 -> 0x10,0x11 buffered, S_TREADY[0]=0 once count=2; M_TDATA holds 0x10 stable; on M_TREADY=1, 0x10,0x11,0x12 drain in order.
- Single-beat packets alternating from sources 1 and 2 with M_TREADY=1 -> one beat every 2 cycles (bubble), GRANT alternates 4'b0010/4'b0100.
- Assert RST_N low after beat 2 of a 4-beat packet -> outputs immediately take reset values; after release, GRANT=0, PKT_CNT=0, next arbitration starts from index 0.

Source files
------------

// File: rtl/axis_inject_arbiter.sv
// Packet-level round-robin arbiter feeding one mesh injection port.
// A grant is held from a packet's first beat to its TLAST beat; output goes through a 2-entry registered buffer.
module axis_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TDATAW  = 32,
  parameter int TDESTW  = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         AXIS_S_TVALID,
  output logic [NUM_REQ-1:0]         AXIS_S_TREADY,
  input  logic [NUM_REQ*TDATAW-1:0]  AXIS_S_TDATA,
  input  logic [NUM_REQ-1:0]         AXIS_S_TLAST,
  input  logic [NUM_REQ*TDESTW-1:0]  AXIS_S_TDEST,
  output logic                       AXIS_M_TVALID,
  input  logic                       AXIS_M_TREADY,
  output logic [TDATAW-1:0]          AXIS_M_TDATA,
  output logic                       AXIS_M_TLAST,
  output logic [TDESTW-1:0]          AXIS_M_TDEST,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic [15:0]                PKT_CNT
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic [IDXW-1:0]     rr_ptr;
  logic [IDXW-1:0]     gnt_idx;
  logic [IDXW-1:0]     sel_idx;
  logic [IDXW-1:0]     cand;
  logic [NUM_REQ-1:0]  sel_onehot;
  logic                sel_found;
  int                  scan_j;

  logic [TDATAW-1:0]   in_data_p0;
  logic                in_last_p0;
  logic [TDESTW-1:0]   in_dest_p0;
  logic                push;
  logic                adv;

  logic                head_vld_p1;
  logic                skid_vld_p1;
  logic [TDATAW-1:0]   skid_data_p1;
  logic                skid_last_p1;
  logic [TDESTW-1:0]   skid_dest_p1;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    scan_j    = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_j = int'(rr_ptr) + k;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      cand = IDXW'(scan_j);
      if (!sel_found && AXIS_S_TVALID[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_onehot = NUM_REQ'(1) << sel_idx;
  end

  always_comb begin
    in_data_p0 = '0;
    in_last_p0 = 1'b0;
    in_dest_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        in_data_p0 = AXIS_S_TDATA[i*TDATAW +: TDATAW];
        in_last_p0 = AXIS_S_TLAST[i];
        in_dest_p0 = AXIS_S_TDEST[i*TDESTW +: TDESTW];
      end
    end
  end

  // Ready depends only on registered state, never on AXIS_M_TREADY.
  assign AXIS_S_TREADY = (state == LOCKED && !(head_vld_p1 && skid_vld_p1)) ? GRANT : '0;
  assign push          = |(AXIS_S_TVALID & AXIS_S_TREADY);
  assign adv           = !head_vld_p1 || AXIS_M_TREADY;
  assign AXIS_M_TVALID = head_vld_p1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      GRANT   <= '0;
      PKT_CNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            GRANT   <= sel_onehot;
            gnt_idx <= sel_idx;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && in_last_p0) begin
            state   <= IDLE;
            GRANT   <= '0;
            rr_ptr  <= (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
            PKT_CNT <= PKT_CNT + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: head register (drives AXIS_M_*) backed by one skid entry ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_vld_p1  <= 1'b0;
      skid_vld_p1  <= 1'b0;
      AXIS_M_TDATA <= '0;
      AXIS_M_TLAST <= 1'b0;
      AXIS_M_TDEST <= '0;
    end else if (adv) begin
      if (skid_vld_p1) begin
        AXIS_M_TDATA <= skid_data_p1;
        AXIS_M_TLAST <= skid_last_p1;
        AXIS_M_TDEST <= skid_dest_p1;
        head_vld_p1  <= 1'b1;
        skid_vld_p1  <= push;
      end else if (push) begin
        AXIS_M_TDATA <= in_data_p0;
        AXIS_M_TLAST <= in_last_p0;
        AXIS_M_TDEST <= in_dest_p0;
        head_vld_p1  <= 1'b1;
      end else begin
        head_vld_p1  <= 1'b0;
      end
    end else if (push) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && (skid_vld_p1 ? adv : !adv)) begin
      skid_data_p1 <= in_data_p0;
      skid_last_p1 <= in_last_p0;
      skid_dest_p1 <= in_dest_p0;
    end
  end

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// Directed bench for axis_inject_arbiter: arbitration order, packet locking, buffering and reset.
module tb_axis_inject_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  S_TVALID;
  logic [N-1:0]  S_TREADY;
  logic [N*DW-1:0] S_TDATA;
  logic [N-1:0]  S_TLAST;
  logic [N*SW-1:0] S_TDEST;
  logic          M_TVALID;
  logic          M_TREADY;
  logic [DW-1:0] M_TDATA;
  logic          M_TLAST;
  logic [SW-1:0] M_TDEST;
  logic [N-1:0]  GRANT;
  logic [15:0]   PKT_CNT;

  int checks = 0;
  int failures = 0;

  int          len [N];
  int          bidx[N];
  int          npk [N];
  logic [31:0] cur [N];
  logic [3:0]  dst [N];
  logic        hold[N];
  logic [31:0] mq[$];
  logic [N-1:0] gq[$];

  axis_inject_arbiter #(.NUM_REQ(N), .TDATAW(DW), .TDESTW(SW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AXIS_S_TVALID(S_TVALID), .AXIS_S_TREADY(S_TREADY), .AXIS_S_TDATA(S_TDATA),
    .AXIS_S_TLAST(S_TLAST), .AXIS_S_TDEST(S_TDEST),
    .AXIS_M_TVALID(M_TVALID), .AXIS_M_TREADY(M_TREADY), .AXIS_M_TDATA(M_TDATA),
    .AXIS_M_TLAST(M_TLAST), .AXIS_M_TDEST(M_TDEST),
    .GRANT(GRANT), .PKT_CNT(PKT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      S_TVALID[i]          = (npk[i] > 0) && !hold[i];
      S_TDATA[i*DW +: DW]  = cur[i];
      S_TLAST[i]           = (bidx[i] == len[i] - 1);
      S_TDEST[i*SW +: SW]  = dst[i];
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      len[i] = 1; bidx[i] = 0; npk[i] = 0; cur[i] = '0; dst[i] = '0; hold[i] = 1'b0;
    end
    drive();
  endtask

  // One clock: record handshakes seen before the edge, advance the source model after it.
  task automatic cycle();
    logic [N-1:0] acc;
    logic         mv;
    logic [31:0]  mw;
    logic [N-1:0] gprev;
    acc   = S_TVALID & S_TREADY;
    mv    = M_TVALID & M_TREADY;
    mw    = {15'b0, M_TLAST, M_TDATA[15:0]};
    gprev = GRANT;
    @(posedge CLK); #1;
    if (mv) mq.push_back(mw);
    if (gprev == '0 && GRANT != '0) gq.push_back(GRANT);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        cur[i] = cur[i] + 32'd1;
        if (bidx[i] == len[i] - 1) begin
          bidx[i] = 0;
          npk[i]  = npk[i] - 1;
        end else begin
          bidx[i] = bidx[i] + 1;
        end
      end
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 100) begin
      cycle();
      n++;
      busy = M_TVALID || (GRANT != '0);
      for (int i = 0; i < N; i++) if (npk[i] > 0) busy = 1'b1;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] exp2[6];
    logic [31:0] exp4[3];
    M_TREADY = 1'b1;
    reset_model();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_grant",  32'(GRANT),    32'd0);
    chk("rst_pkt",    32'(PKT_CNT),  32'd0);
    chk("rst_mvalid", 32'(M_TVALID), 32'd0);
    chk("rst_mdata",  M_TDATA,       32'd0);
    chk("rst_sready", 32'(S_TREADY), 32'd0);
    RST_N = 1'b1;

    // Source 2, 3-beat packet
    len[2] = 3; npk[2] = 1; cur[2] = 32'hA0; dst[2] = 4'd3;
    drive();
    chk("t1_idle_grant", 32'(GRANT), 32'd0);
    cycle();
    chk("t1_grant",  32'(GRANT),    32'h4);
    chk("t1_sready", 32'(S_TREADY), 32'h4);
    chk("t1_mv0",    32'(M_TVALID), 32'd0);
    cycle();
    chk("t1_b0_v",    32'(M_TVALID), 32'd1);
    chk("t1_b0_d",    M_TDATA,       32'hA0);
    chk("t1_b0_dest", 32'(M_TDEST),  32'd3);
    chk("t1_b0_last", 32'(M_TLAST),  32'd0);
    cycle();
    chk("t1_b1_d",    M_TDATA,       32'hA1);
    cycle();
    chk("t1_b2_d",    M_TDATA,       32'hA2);
    chk("t1_b2_last", 32'(M_TLAST),  32'd1);
    chk("t1_gclr",    32'(GRANT),    32'd0);
    chk("t1_pkt",     32'(PKT_CNT),  32'd1);
    cycle();
    chk("t1_mv_end",  32'(M_TVALID), 32'd0);
    chk("t1_hold_d",  M_TDATA,       32'hA2);

    // Sources 0,1,3 with 2-beat packets; pointer sits at 3 after source 2
    mq.delete(); gq.delete();
    len[0] = 2; npk[0] = 1; cur[0] = 32'h000; dst[0] = 4'd0;
    len[1] = 2; npk[1] = 1; cur[1] = 32'h100; dst[1] = 4'd1;
    len[3] = 2; npk[3] = 1; cur[3] = 32'h300; dst[3] = 4'd3;
    drive();
    drain("t2_timeout");
    exp2[0] = 32'h00300; exp2[1] = 32'h10301; exp2[2] = 32'h00000;
    exp2[3] = 32'h10001; exp2[4] = 32'h00100; exp2[5] = 32'h10101;
    chk("t2_nbeats", 32'(mq.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("t2_beat%0d", k), mq[k], exp2[k]);
    chk("t2_ngrants", 32'(gq.size()), 32'd3);
    chk("t2_g0", 32'(gq[0]), 32'h8);
    chk("t2_g1", 32'(gq[1]), 32'h1);
    chk("t2_g2", 32'(gq[2]), 32'h2);
    chk("t2_pkt", 32'(PKT_CNT), 32'd4);

    // Source 0 stalls mid-packet while source 1 waits
    len[0] = 2; npk[0] = 1; cur[0] = 32'h50;
    len[1] = 1; npk[1] = 1; cur[1] = 32'h60;
    drive();
    cycle();
    chk("t3_grant", 32'(GRANT), 32'h1);
    cycle();
    chk("t3_b0_d", M_TDATA, 32'h50);
    hold[0] = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("t3_hold_g%0d", k), 32'(GRANT), 32'h1);
      chk($sformatf("t3_hold_r1_%0d", k), 32'(S_TREADY[1]), 32'd0);
    end
    hold[0] = 1'b0;
    drive();
    cycle();
    chk("t3_end0_g",   32'(GRANT),   32'd0);
    chk("t3_end0_pkt", 32'(PKT_CNT), 32'd5);
    cycle();
    chk("t3_g1", 32'(GRANT), 32'h2);
    cycle();
    chk("t3_s1_d",    M_TDATA,      32'h60);
    chk("t3_s1_last", 32'(M_TLAST), 32'd1);
    chk("t3_pkt",     32'(PKT_CNT), 32'd6);
    drain("t3_timeout");

    // Back-pressure: buffer fills to two entries
    M_TREADY = 1'b0;
    len[0] = 3; npk[0] = 1; cur[0] = 32'h10;
    drive();
    cycle();
    chk("t4_grant", 32'(GRANT), 32'h1);
    cycle();
    chk("t4_b0_v", 32'(M_TVALID), 32'd1);
    chk("t4_b0_d", M_TDATA, 32'h10);
    chk("t4_rdy1", 32'(S_TREADY[0]), 32'd1);
    cycle();
    chk("t4_full_rdy", 32'(S_TREADY[0]), 32'd0);
    chk("t4_full_d",   M_TDATA, 32'h10);
    cycle();
    chk("t4_stall_d",  M_TDATA, 32'h10);
    chk("t4_stall_v",  32'(M_TVALID), 32'd1);
    chk("t4_stall_rdy", 32'(S_TREADY[0]), 32'd0);
    mq.delete();
    M_TREADY = 1'b1;
    drain("t4_timeout");
    exp4[0] = 32'h00010; exp4[1] = 32'h00011; exp4[2] = 32'h10012;
    chk("t4_nbeats", 32'(mq.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("t4_beat%0d", k), mq[k], exp4[k]);
    chk("t4_pkt", 32'(PKT_CNT), 32'd7);

    // Alternating single-beat packets from sources 1 and 2
    len[1] = 1; npk[1] = 2; cur[1] = 32'h70;
    len[2] = 1; npk[2] = 2; cur[2] = 32'h80;
    drive();
    cycle();
    chk("t5_g_a", 32'(GRANT), 32'h2);
    cycle();
    chk("t5_d_a",  M_TDATA, 32'h70);
    chk("t5_v_a",  32'(M_TVALID), 32'd1);
    chk("t5_gc_a", 32'(GRANT), 32'd0);
    cycle();
    chk("t5_g_b",  32'(GRANT), 32'h4);
    chk("t5_bub_b", 32'(M_TVALID), 32'd0);
    cycle();
    chk("t5_d_b",  M_TDATA, 32'h80);
    cycle();
    chk("t5_g_c",  32'(GRANT), 32'h2);
    chk("t5_bub_c", 32'(M_TVALID), 32'd0);
    cycle();
    chk("t5_d_c",  M_TDATA, 32'h71);
    chk("t5_pkt_c", 32'(PKT_CNT), 32'd10);
    cycle();
    chk("t5_g_d",  32'(GRANT), 32'h4);
    cycle();
    chk("t5_d_d",  M_TDATA, 32'h81);
    chk("t5_pkt",  32'(PKT_CNT), 32'd11);
    drain("t5_timeout");

    // Reset in the middle of a 4-beat packet
    len[0] = 4; npk[0] = 1; cur[0] = 32'h90;
    drive();
    cycle();
    chk("t6_grant", 32'(GRANT), 32'h1);
    cycle();
    cycle();
    chk("t6_pre_d", M_TDATA, 32'h91);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_g",  32'(GRANT),    32'd0);
    chk("t6_rst_v",  32'(M_TVALID), 32'd0);
    chk("t6_rst_d",  M_TDATA,       32'd0);
    chk("t6_rst_r",  32'(S_TREADY), 32'd0);
    chk("t6_rst_p",  32'(PKT_CNT),  32'd0);
    reset_model();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    len[0] = 1; npk[0] = 1; cur[0] = 32'hC0;
    len[3] = 1; npk[3] = 1; cur[3] = 32'hC3;
    drive();
    cycle();
    chk("t6_g0", 32'(GRANT), 32'h1);
    cycle();
    chk("t6_d0",  M_TDATA, 32'hC0);
    chk("t6_p1",  32'(PKT_CNT), 32'd1);
    cycle();
    chk("t6_g3", 32'(GRANT), 32'h8);
    cycle();
    chk("t6_d3",  M_TDATA, 32'hC3);
    chk("t6_p2",  32'(PKT_CNT), 32'd2);
    drain("t6_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
